// File: rtl/nn_input_feeder.sv
// nn_input_feeder
//   Purpose : host-side feeder for a sequential NN top. Holds one DEPTH-sample
//             input vector, serves the network's indexed fill reads, raises the
//             network request and captures the DEPTH parallel results.
//   Latency : fill reads and result readback are one cycle (registered).
//   Ports   : host_we/host_waddr/host_wdata - input buffer write port
//             start/busy/done/err/cycles     - run control and status
//             res_raddr/res_rdata            - registered result readback
//             fill/ack_fill/net_rd_*         - fill channel to the network
//             net_req/ack_network/net_result - run request and result capture
module nn_input_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_we,
  input  logic [IDX_W-1:0]        host_waddr,
  input  logic [DATA_W-1:0]       host_wdata,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [CNT_W-1:0]        cycles,
  input  logic [IDX_W-1:0]        res_raddr,
  output logic [DATA_W-1:0]       res_rdata,
  output logic                    fill,
  input  logic                    ack_fill,
  input  logic                    net_rd_strobe,
  input  logic [IDX_W-1:0]        net_rd_idx,
  output logic [DATA_W-1:0]       net_rd_data,
  output logic                    net_req,
  input  logic                    ack_network,
  input  logic [DEPTH*DATA_W-1:0] net_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              fill_q, fill_d;
  logic              net_req_q, net_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [DATA_W-1:0] net_rd_data_q, net_rd_data_d;
  logic [DATA_W-1:0] res_rdata_q, res_rdata_d;
  logic [DATA_W-1:0] buf_q    [DEPTH];
  logic [DATA_W-1:0] buf_d    [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [DATA_W-1:0] result_d [DEPTH];

  logic start_ok;
  logic err_set;

  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    net_req_d     = net_req_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cycles_d      = cycles_q;
    net_rd_data_d = net_rd_data_q;
    buf_d         = buf_q;
    result_d      = result_q;

    start_ok = (state_q == ST_IDLE) && start;

    // Any channel activity outside its own phase is a protocol violation.
    err_set = (net_rd_strobe && (state_q != ST_FILL)) ||
              (ack_fill      && (state_q != ST_FILL)) ||
              (ack_network   && (state_q != ST_RUN));

    // An accepted start clears the sticky flag, but a violation in the same
    // cycle still wins so it is never lost.
    err_d = (start_ok ? 1'b0 : err_q) | err_set;

    // Count every cycle spent busy; restarted from zero on an accepted start.
    if ((state_q != ST_IDLE) && (cycles_q != CNT_MAX)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FILL;
          fill_d   = 1'b1;
          busy_d   = 1'b1;
          cycles_d = '0;
        end
      end
      ST_FILL: begin
        if (net_rd_strobe) begin
          net_rd_data_d = buf_q[net_rd_idx];
        end
        if (ack_fill) begin
          state_d   = ST_RUN;
          fill_d    = 1'b0;
          net_req_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ack_network) begin
          for (int i = 0; i < DEPTH; i++) begin
            result_d[i] = net_result[DATA_W*i +: DATA_W];
          end
          state_d   = ST_IDLE;
          net_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        fill_d    = 1'b0;
        net_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    // The vector is frozen while the network is reading it.
    if (host_we && (state_q != ST_FILL)) begin
      buf_d[host_waddr] = host_wdata;
    end

    res_rdata_d = result_q[res_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fill_q        <= 1'b0;
      net_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cycles_q      <= '0;
      net_rd_data_q <= '0;
      res_rdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      net_req_q     <= net_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cycles_q      <= cycles_d;
      net_rd_data_q <= net_rd_data_d;
      res_rdata_q   <= res_rdata_d;
      result_q      <= result_d;
    end
  end

  // The input vector deliberately survives reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign fill        = fill_q;
  assign net_req     = net_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cycles      = cycles_q;
  assign net_rd_data = net_rd_data_q;
  assign res_rdata   = res_rdata_q;

endmodule

// File: tb/tb_nn_input_feeder.sv
module tb_nn_input_feeder;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  host_we;
  logic [IW-1:0]         host_waddr;
  logic [DW-1:0]         host_wdata;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CW-1:0]         cycles;
  logic [IW-1:0]         res_raddr;
  logic [DW-1:0]         res_rdata;
  logic                  fill;
  logic                  ack_fill;
  logic                  net_rd_strobe;
  logic [IW-1:0]         net_rd_idx;
  logic [DW-1:0]         net_rd_data;
  logic                  net_req;
  logic                  ack_network;
  logic [DEPTH*DW-1:0]   net_result;

  nn_input_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .start(start), .busy(busy), .done(done), .err(err), .cycles(cycles),
    .res_raddr(res_raddr), .res_rdata(res_rdata),
    .fill(fill), .ack_fill(ack_fill),
    .net_rd_strobe(net_rd_strobe), .net_rd_idx(net_rd_idx), .net_rd_data(net_rd_data),
    .net_req(net_req), .ack_network(ack_network), .net_result(net_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          strobe;
    logic [IW-1:0] idx;
    logic          we;
    logic [IW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [13];
  logic [DW-1:0] bufvals [DEPTH];
  logic [DW-1:0] rd_sb [$];
  logic [DW-1:0] res_sb [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_rd(input string nm);
    logic [DW-1:0] e;
    if (rd_sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: read scoreboard empty", nm);
    end else begin
      e = rd_sb.pop_front();
      chk(nm, 32'(net_rd_data), 32'(e));
    end
  endtask

  task automatic pop_res(input string nm);
    logic [DW-1:0] e;
    if (res_sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: result scoreboard empty", nm);
    end else begin
      e = res_sb.pop_front();
      chk(nm, 32'(res_rdata), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; host_we = 1'b0; host_waddr = '0; host_wdata = '0; start = 1'b0;
    res_raddr = '0; ack_fill = 1'b0; net_rd_strobe = 1'b0; net_rd_idx = '0;
    ack_network = 1'b0; net_result = '0;

    bufvals[0] = 8'd10;   bufvals[1] = 8'hFD; bufvals[2] = 8'd7; bufvals[3] = 8'd0;
    bufvals[4] = 8'h7F;   bufvals[5] = 8'h80; bufvals[6] = 8'd1; bufvals[7] = 8'd2;
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, IW'(i), 1'b0, '0, '0, bufvals[i]};
    end
    vecs[8]  = '{1'b1, 3'd7, 1'b0, 3'd0, 8'd0,  8'd2};
    vecs[9]  = '{1'b1, 3'd0, 1'b0, 3'd0, 8'd0,  8'd10};
    vecs[10] = '{1'b1, 3'd7, 1'b0, 3'd0, 8'd0,  8'd2};
    vecs[11] = '{1'b1, 3'd1, 1'b1, 3'd2, 8'd99, 8'hFD};
    vecs[12] = '{1'b1, 3'd2, 1'b0, 3'd0, 8'd0,  8'd7};

    // Reset state
    step(); step();
    chk("rst_fill", 32'(fill), 0);
    chk("rst_net_req", 32'(net_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cycles", 32'(cycles), 0);
    chk("rst_rd_data", 32'(net_rd_data), 0);
    chk("rst_res_rdata", 32'(res_rdata), 0);
    rst = 1'b0;
    step();

    // Load the input vector
    for (int i = 0; i < DEPTH; i++) begin
      host_we = 1'b1; host_waddr = IW'(i); host_wdata = bufvals[i];
      step();
    end
    host_we = 1'b0;

    // Basic run: start then the fill table
    start = 1'b1; step(); start = 1'b0;
    chk("start_fill", 32'(fill), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_cycles", 32'(cycles), 0);
    chk("start_net_req", 32'(net_req), 0);

    for (int v = 0; v < 13; v++) begin
      net_rd_strobe = vecs[v].strobe; net_rd_idx = vecs[v].idx;
      host_we = vecs[v].we; host_waddr = vecs[v].waddr; host_wdata = vecs[v].wdata;
      if (vecs[v].strobe) rd_sb.push_back(vecs[v].exp);
      step();
      net_rd_strobe = 1'b0; host_we = 1'b0;
      pop_rd($sformatf("fill_vec%0d", v));
    end
    chk("fill_still_high", 32'(fill), 1);

    // Strobe together with ack_fill
    net_rd_strobe = 1'b1; net_rd_idx = 3'd5; ack_fill = 1'b1;
    rd_sb.push_back(8'h80);
    step();
    net_rd_strobe = 1'b0; ack_fill = 1'b0;
    pop_rd("same_cycle_rd");
    chk("ackfill_net_req", 32'(net_req), 1);
    chk("ackfill_fill", 32'(fill), 0);
    chk("ackfill_busy", 32'(busy), 1);

    // RUN: write is applied, start ignored
    host_we = 1'b1; host_waddr = 3'd2; host_wdata = 8'd99;
    step();
    host_we = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("run_start_busy", 32'(busy), 1);
    chk("run_start_net_req", 32'(net_req), 1);
    chk("run_start_err", 32'(err), 0);
    chk("run_start_fill", 32'(fill), 0);
    step(); step();
    for (int i = 0; i < DEPTH; i++) net_result[DW*i +: DW] = DW'(i*5);
    ack_network = 1'b1; step(); ack_network = 1'b0;
    chk("ack_done", 32'(done), 1);
    chk("ack_net_req", 32'(net_req), 0);
    chk("ack_busy", 32'(busy), 0);
    chk("sat_cycles_basic", 32'(cycles), 15);
    step();
    chk("done_pulse_end", 32'(done), 0);

    // Result readback through the scoreboard
    for (int i = 0; i < DEPTH; i++) begin
      res_raddr = IW'(i);
      res_sb.push_back(DW'(i*5));
      step();
      pop_res($sformatf("res_rd%0d", i));
    end

    // Strobe in IDLE is an error and leaves the read data alone
    net_rd_strobe = 1'b1; net_rd_idx = 3'd0; step(); net_rd_strobe = 1'b0;
    chk("idle_strobe_err", 32'(err), 1);
    chk("idle_strobe_rd_hold", 32'(net_rd_data), 32'h80);

    // Minimum run; start clears err; write from RUN is visible
    start = 1'b1; step(); start = 1'b0;
    chk("min_err_cleared", 32'(err), 0);
    chk("min_cycles0", 32'(cycles), 0);
    net_rd_strobe = 1'b1; net_rd_idx = 3'd2; ack_fill = 1'b1;
    rd_sb.push_back(8'd99);
    step();
    net_rd_strobe = 1'b0; ack_fill = 1'b0;
    pop_rd("min_rd_written");
    ack_network = 1'b1; step(); ack_network = 1'b0;
    chk("min_done", 32'(done), 1);
    chk("min_cycles", 32'(cycles), 2);

    // Reset in RUN
    start = 1'b1; step(); start = 1'b0;
    ack_fill = 1'b1; step(); ack_fill = 1'b0;
    res_raddr = 3'd1; step();
    chk("pre_rst_res", 32'(res_rdata), 5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_net_req", 32'(net_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_cycles", 32'(cycles), 0);
    chk("mid_rst_res_rdata", 32'(res_rdata), 0);
    step();
    chk("mid_rst_result_cleared", 32'(res_rdata), 0);

    // Buffer survives reset; long RUN saturates the counter
    start = 1'b1; step(); start = 1'b0;
    net_rd_strobe = 1'b1; net_rd_idx = 3'd2;
    rd_sb.push_back(8'd99);
    step();
    net_rd_strobe = 1'b0;
    pop_rd("buf_retained");
    ack_fill = 1'b1; step(); ack_fill = 1'b0;
    repeat (20) step();
    chk("sat_cycles", 32'(cycles), 15);
    chk("long_run_busy", 32'(busy), 1);
    for (int i = 0; i < DEPTH; i++) net_result[DW*i +: DW] = DW'(i + 100);
    ack_network = 1'b1; step(); ack_network = 1'b0;
    chk("long_done", 32'(done), 1);
    res_raddr = 3'd3; res_sb.push_back(8'd103);
    step();
    pop_res("long_res3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
